intf_or_sched: RTL and testbench
================================

Name: intf_or_sched

Overview:
- Round-robin scheduler that shares one intf_or unit between NREQ requesters.
- Each requester posts an (a, b) operand pair into a private 1-entry buffer.
- The scheduler grants one buffered pair at a time, sequences the unit's a, b and y methods over rdy/en handshakes, and returns the result tagged with requester id and an error flag.
- A timeout guards against a unit that never presents y.

Parameters:
- NREQ, 2, number of requesters (2..8)
- DATA_W, 1, operand/result width; must match the intf_or instance
- IDW, 1, requester id width; must be >= clog2(NREQ)
- TIMEOUT, 16, max cycles in WAIT_Y before abort; 0 disables the timeout (16-bit counter)

Ports:
- CLK  input  1  clock, rising edge
- RST_N  input  1  reset, asynchronous, active-high despite the name
- req_a_data  input  NREQ*DATA_W  per-requester a operand; slice i belongs to requester i
- req_b_data  input  NREQ*DATA_W  per-requester b operand
- req_en  input  NREQ  per-requester put enable
- req_rdy  output  NREQ  per-requester buffer empty
- resp_data  output  DATA_W  result
- resp_id  output  IDW  requester that owns the result
- resp_err  output  1  1 = timeout abort; resp_data is 0
- resp_rdy  output  1  result available
- resp_en  input  1  result consume
- dut_a_data  output  DATA_W  to intf_or a_data
- dut_a_en  output  1  to intf_or a_en
- dut_a_rdy  input  1  from intf_or a_rdy
- dut_b_data  output  DATA_W  to intf_or b_data
- dut_b_en  output  1  to intf_or b_en
- dut_b_rdy  input  1  from intf_or b_rdy
- dut_y_en  output  1  to intf_or y_en
- dut_y_data  input  DATA_W  from intf_or y_data
- dut_y_rdy  input  1  from intf_or y_rdy
- busy  output  1  state != IDLE

Behaviour:
Handshakes
- A method fires on a clock edge where both en and rdy are 1.
- An en with rdy low is ignored and has no effect on any state.

Reset (asynchronous, while RST_N=1)
- State = IDLE, all buffers empty, rr_ptr = 0, timeout counter = 0, result registers = 0.
- Outputs while reset is asserted: req_rdy = 0, resp_rdy = 0, all dut_*_en = 0, busy = 0.
- First edge after release: req_rdy = all ones.

Buffers
- req_rdy[i] = ~full[i].
- A req_en[i] fire loads the a/b slices for requester i and sets full[i].
- full[i] clears on the edge its pair is granted; the buffer can be refilled from the next cycle.

Arbitration (IDLE only)
- Candidate set = requesters with full set.
- Search starts at rr_ptr and wraps modulo NREQ; the first full requester is granted.
- On grant, the pair and id are copied to op_a, op_b, op_id; rr_ptr <= (grant+1) mod NREQ; state moves to SEND_A.
- No full buffer: remain in IDLE.

FSM (moore outputs; the dut_*_en signals are gated combinationally by the matching rdy)
- IDLE: no dut_*_en asserted.
- SEND_A: dut_a_data = op_a, dut_a_en = dut_a_rdy. On fire, go to SEND_B.
- SEND_B: dut_b_data = op_b, dut_b_en = dut_b_rdy. On fire, go to WAIT_Y and clear the counter.
- WAIT_Y: dut_y_en = dut_y_rdy.
  - On fire: resp_data <= dut_y_data, resp_err <= 0, go to RESP.
  - Otherwise the counter increments. If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without a fire: resp_data <= 0, resp_err <= 1, go to RESP.
- RESP: resp_rdy = 1, resp_id = op_id. On a resp_en fire, go to IDLE.
- When not driven, dut_a_data and dut_b_data hold op_a and op_b; resp_* hold their last values.

Latency
- Unit always ready and consumer always enabling: req_en fire at edge E0 -> grant E1 -> a fire E2 -> b fire E3 -> y fire E4 -> resp_rdy high after E4 -> consumed at E5.
- Next grant no earlier than E6 (IDLE cycle).

Boundaries
- All NREQ buffers full: served strictly in rotating order, no starvation.
- The granted requester may refill while its own op is in flight; it is re-served only after the rotation reaches it again.
- Backpressure on resp_en: the FSM holds in RESP; other buffers keep accepting puts.
- Reset mid-operation: in-flight op is dropped with no response; buffers are lost.
- A dut_y_rdy arriving on the same edge the timeout would fire: the fire wins, resp_err = 0.

Test Plan:
- Reset release, NREQ=2, DATA_W=1 -> req_rdy=2'b11, busy=0, resp_rdy=0; put req0 a=1 b=0 with unit always ready -> resp_rdy on the 4th edge after put, resp_data=1, resp_id=0, resp_err=0.
- Both requesters put in the same cycle (req0 a=0 b=0, req1 a=1 b=1), rr_ptr=0 -> responses in order id0 data 0, then id1 data 1; rr_ptr=0 again after both.
- req1 re-puts immediately after every grant while req0 is always full -> grants alternate 0,1,0,1 over 8 ops; no requester served twice in a row.
- dut_a_rdy held low for 5 cycles -> dut_a_en stays 0, state holds SEND_A, no b or y activity; completes normally after rdy rises.
- TIMEOUT=4, dut_y_rdy never asserted -> resp_rdy after exactly 4 WAIT_Y cycles with resp_err=1, resp_data=0; next op succeeds normally.
- RST_N pulsed for 1 cycle while in WAIT_Y with req1 buffered -> no response; after release state=IDLE, req_rdy=2'b11, busy=0.

Source files
------------

// File: rtl/intf_or_sched.sv
// intf_or_sched: round-robin scheduler that shares one intf_or unit among
// NREQ requesters. Each requester owns a 1-entry (a, b) buffer. The scheduler
// grants one pair at a time, drives the unit's a, b and y methods over rdy/en
// handshakes, and returns the result tagged with the requester id. A WAIT_Y
// timeout returns an error response when the unit never presents y.
// RST_N is an asynchronous reset that is active HIGH, despite its name.

module intf_or_sched #(
    parameter int NREQ    = 2,
    parameter int DATA_W  = 1,
    parameter int IDW     = 1,
    parameter int TIMEOUT = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [NREQ*DATA_W-1:0]   req_a_data,
    input  logic [NREQ*DATA_W-1:0]   req_b_data,
    input  logic [NREQ-1:0]          req_en,
    output logic [NREQ-1:0]          req_rdy,
    output logic [DATA_W-1:0]        resp_data,
    output logic [IDW-1:0]           resp_id,
    output logic                     resp_err,
    output logic                     resp_rdy,
    input  logic                     resp_en,
    output logic [DATA_W-1:0]        dut_a_data,
    output logic                     dut_a_en,
    input  logic                     dut_a_rdy,
    output logic [DATA_W-1:0]        dut_b_data,
    output logic                     dut_b_en,
    input  logic                     dut_b_rdy,
    output logic                     dut_y_en,
    input  logic [DATA_W-1:0]        dut_y_data,
    input  logic                     dut_y_rdy,
    output logic                     busy
);

    // One extra bit so that rr_ptr + offset cannot overflow before the wrap.
    localparam int          SW      = IDW + 1;
    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TO_LAST = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND_A = 3'd1,
        ST_SEND_B = 3'd2,
        ST_WAIT_Y = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t              state_r;
    logic [NREQ-1:0]     full_r;
    logic [NREQ-1:0]     req_rdy_r;
    logic [DATA_W-1:0]   buf_a_r [NREQ];
    logic [DATA_W-1:0]   buf_b_r [NREQ];
    logic [IDW-1:0]      rr_ptr_r;
    logic [DATA_W-1:0]   op_a_r;
    logic [DATA_W-1:0]   op_b_r;
    logic [IDW-1:0]      op_id_r;
    logic [15:0]         wait_cnt_r;
    logic [DATA_W-1:0]   resp_data_r;
    logic [IDW-1:0]      resp_id_r;
    logic                resp_err_r;
    logic                resp_rdy_r;
    logic                busy_r;

    logic [NREQ-1:0]     put_fire_s;
    logic [NREQ-1:0]     grant_clr_s;
    logic [NREQ-1:0]     full_nxt_s;
    logic [2*NREQ-1:0]   rot2_s;
    logic [NREQ-1:0]     rot_s;
    logic [SW-1:0]       off_s;
    logic [SW-1:0]       sum_s;
    logic [IDW-1:0]      grant_id_s;
    logic [IDW-1:0]      ptr_nxt_s;
    logic                grant_vld_s;
    logic                grant_fire_s;
    logic [DATA_W-1:0]   sel_a_s;
    logic [DATA_W-1:0]   sel_b_s;
    logic                timeout_hit_s;

    // A put only lands in an empty buffer; req_rdy is the registered ~full.
    assign put_fire_s   = req_en & req_rdy_r;
    assign grant_fire_s = (state_r == ST_IDLE) & grant_vld_s;

    assign req_rdy    = req_rdy_r;
    assign resp_data  = resp_data_r;
    assign resp_id    = resp_id_r;
    assign resp_err   = resp_err_r;
    assign resp_rdy   = resp_rdy_r;
    assign busy       = busy_r;

    // Operand buses always present the in-flight pair; enables follow rdy.
    assign dut_a_data = op_a_r;
    assign dut_b_data = op_b_r;
    assign dut_a_en   = (state_r == ST_SEND_A) & dut_a_rdy;
    assign dut_b_en   = (state_r == ST_SEND_B) & dut_b_rdy;
    assign dut_y_en   = (state_r == ST_WAIT_Y) & dut_y_rdy;

    // Round-robin search: rotate occupancy so bit 0 is rr_ptr, take the lowest set bit.
    always_comb begin
        rot2_s      = {full_r, full_r} >> rr_ptr_r;
        rot_s       = rot2_s[NREQ-1:0];
        grant_vld_s = |rot_s;
        off_s       = {SW{1'b0}};
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                off_s = SW'(k);
            end else begin
                off_s = off_s;
            end
        end
        sum_s = {1'b0, rr_ptr_r} + off_s;
        if (sum_s >= SW'(NREQ)) begin
            grant_id_s = IDW'(sum_s - SW'(NREQ));
        end else begin
            grant_id_s = sum_s[IDW-1:0];
        end
        if (grant_id_s == IDW'(NREQ - 1)) begin
            ptr_nxt_s = {IDW{1'b0}};
        end else begin
            ptr_nxt_s = grant_id_s + IDW'(1);
        end
    end

    // Pick the granted buffer's operands and the one-hot clear for its full flag.
    always_comb begin
        sel_a_s     = {DATA_W{1'b0}};
        sel_b_s     = {DATA_W{1'b0}};
        grant_clr_s = {NREQ{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (grant_id_s == IDW'(k)) begin
                sel_a_s        = buf_a_r[k];
                sel_b_s        = buf_b_r[k];
                grant_clr_s[k] = grant_fire_s;
            end else begin
                grant_clr_s[k] = 1'b0;
            end
        end
        full_nxt_s = (full_r | put_fire_s) & ~grant_clr_s;
    end

    // Timeout fires on the TIMEOUT-th WAIT_Y cycle without a y fire.
    always_comb begin
        if (TO_EN && (wait_cnt_r == TO_LAST)) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Requester buffers: load on put, release on grant.
    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            full_r    <= {NREQ{1'b0}};
            req_rdy_r <= {NREQ{1'b0}};
            for (int k = 0; k < NREQ; k++) begin
                buf_a_r[k] <= {DATA_W{1'b0}};
                buf_b_r[k] <= {DATA_W{1'b0}};
            end
        end else begin
            full_r    <= full_nxt_s;
            req_rdy_r <= ~full_nxt_s;
            for (int k = 0; k < NREQ; k++) begin
                if (put_fire_s[k]) begin
                    buf_a_r[k] <= req_a_data[k*DATA_W +: DATA_W];
                    buf_b_r[k] <= req_b_data[k*DATA_W +: DATA_W];
                end else begin
                    buf_a_r[k] <= buf_a_r[k];
                    buf_b_r[k] <= buf_b_r[k];
                end
            end
        end
    end

    // Operation sequencer: grant, send a, send b, wait for y, hold the response.
    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= {IDW{1'b0}};
            op_a_r      <= {DATA_W{1'b0}};
            op_b_r      <= {DATA_W{1'b0}};
            op_id_r     <= {IDW{1'b0}};
            wait_cnt_r  <= 16'd0;
            resp_data_r <= {DATA_W{1'b0}};
            resp_id_r   <= {IDW{1'b0}};
            resp_err_r  <= 1'b0;
            resp_rdy_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_vld_s) begin
                        op_a_r   <= sel_a_s;
                        op_b_r   <= sel_b_s;
                        op_id_r  <= grant_id_s;
                        rr_ptr_r <= ptr_nxt_s;
                        busy_r   <= 1'b1;
                        state_r  <= ST_SEND_A;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_SEND_A: begin
                    if (dut_a_rdy) begin
                        state_r <= ST_SEND_B;
                    end else begin
                        state_r <= ST_SEND_A;
                    end
                end
                ST_SEND_B: begin
                    if (dut_b_rdy) begin
                        wait_cnt_r <= 16'd0;
                        state_r    <= ST_WAIT_Y;
                    end else begin
                        state_r    <= ST_SEND_B;
                    end
                end
                ST_WAIT_Y: begin
                    // A y fire on the timeout cycle still wins.
                    if (dut_y_rdy) begin
                        resp_data_r <= dut_y_data;
                        resp_err_r  <= 1'b0;
                        resp_id_r   <= op_id_r;
                        resp_rdy_r  <= 1'b1;
                        state_r     <= ST_RESP;
                    end else if (timeout_hit_s) begin
                        resp_data_r <= {DATA_W{1'b0}};
                        resp_err_r  <= 1'b1;
                        resp_id_r   <= op_id_r;
                        resp_rdy_r  <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        wait_cnt_r  <= wait_cnt_r + 16'd1;
                        state_r     <= ST_WAIT_Y;
                    end
                end
                ST_RESP: begin
                    if (resp_en) begin
                        resp_rdy_r <= 1'b0;
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r    <= ST_RESP;
                    end
                end
                default: begin
                    resp_rdy_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intf_or_sched.sv
// Self-checking bench for intf_or_sched: a transaction-level reference model
// (buffers, rotation pointer, operation phase) predicts every output each
// cycle; an OR unit is emulated on the dut_* side. Directed scenarios pin the
// model with literal expectations, then a randomized run exercises the rest.

module tb_intf_or_sched;

    localparam int NREQ = 2;
    localparam int DW   = 4;
    localparam int IDW  = 1;
    localparam int TO   = 4;

    localparam int PH_IDLE = 0;
    localparam int PH_A    = 1;
    localparam int PH_B    = 2;
    localparam int PH_Y    = 3;
    localparam int PH_RESP = 4;

    logic                 CLK;
    logic                 RST_N;
    logic [NREQ*DW-1:0]   req_a_data;
    logic [NREQ*DW-1:0]   req_b_data;
    logic [NREQ-1:0]      req_en;
    logic [NREQ-1:0]      req_rdy;
    logic [DW-1:0]        resp_data;
    logic [IDW-1:0]       resp_id;
    logic                 resp_err;
    logic                 resp_rdy;
    logic                 resp_en;
    logic [DW-1:0]        dut_a_data;
    logic                 dut_a_en;
    logic                 dut_a_rdy;
    logic [DW-1:0]        dut_b_data;
    logic                 dut_b_en;
    logic                 dut_b_rdy;
    logic                 dut_y_en;
    logic [DW-1:0]        dut_y_data;
    logic                 dut_y_rdy;
    logic                 busy;

    intf_or_sched #(.NREQ(NREQ), .DATA_W(DW), .IDW(IDW), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_a_data(req_a_data), .req_b_data(req_b_data),
        .req_en(req_en), .req_rdy(req_rdy),
        .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err),
        .resp_rdy(resp_rdy), .resp_en(resp_en),
        .dut_a_data(dut_a_data), .dut_a_en(dut_a_en), .dut_a_rdy(dut_a_rdy),
        .dut_b_data(dut_b_data), .dut_b_en(dut_b_en), .dut_b_rdy(dut_b_rdy),
        .dut_y_en(dut_y_en), .dut_y_data(dut_y_data), .dut_y_rdy(dut_y_rdy),
        .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // stimulus for the next cycle
    bit                 s_rst;
    logic [NREQ-1:0]    s_req_en;
    logic [NREQ*DW-1:0] s_a;
    logic [NREQ*DW-1:0] s_b;
    bit                 s_a_rdy, s_b_rdy, s_y_rdy, s_resp_en;

    // reference model
    bit            m_alive;
    bit            m_full [NREQ];
    logic [DW-1:0] m_a [NREQ];
    logic [DW-1:0] m_b [NREQ];
    int            m_ptr, m_phase, m_wait, m_op_id, m_resp_id;
    logic [DW-1:0] m_op_a, m_op_b, m_resp_data;
    bit            m_resp_err;

    // emulated OR unit
    logic [DW-1:0] u_a, u_b;
    bit            c_a_fire, c_b_fire;
    logic [DW-1:0] c_a_data, c_b_data;

    // responses actually consumed from the DUT
    int obs_id[$];
    int obs_data[$];
    int obs_err[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_alive = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            m_full[i] = 1'b0;
            m_a[i] = '0;
            m_b[i] = '0;
        end
        m_ptr = 0; m_phase = PH_IDLE; m_wait = 0; m_op_id = 0; m_resp_id = 0;
        m_op_a = '0; m_op_b = '0; m_resp_data = '0; m_resp_err = 1'b0;
    endfunction

    // One clock edge of the scheduler's rules, using the inputs held over the edge.
    function automatic void model_update();
        int g;
        if (s_rst) begin
            model_reset();
            return;
        end
        g = -1;
        if (m_phase == PH_IDLE) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && m_full[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (m_alive && !m_full[i] && s_req_en[i]) begin
                m_full[i] = 1'b1;
                m_a[i] = s_a[i*DW +: DW];
                m_b[i] = s_b[i*DW +: DW];
            end
        end
        case (m_phase)
            PH_IDLE: if (g >= 0) begin
                m_op_a = m_a[g]; m_op_b = m_b[g]; m_op_id = g;
                m_full[g] = 1'b0;
                m_ptr = (g + 1) % NREQ;
                m_phase = PH_A;
            end
            PH_A: if (s_a_rdy) m_phase = PH_B;
            PH_B: if (s_b_rdy) begin m_phase = PH_Y; m_wait = 0; end
            PH_Y: begin
                if (s_y_rdy) begin
                    m_resp_data = m_op_a | m_op_b; m_resp_err = 1'b0;
                    m_resp_id = m_op_id; m_phase = PH_RESP;
                end else begin
                    m_wait++;
                    if (TO != 0 && m_wait == TO) begin
                        m_resp_data = '0; m_resp_err = 1'b1;
                        m_resp_id = m_op_id; m_phase = PH_RESP;
                    end
                end
            end
            PH_RESP: if (s_resp_en) m_phase = PH_IDLE;
            default: m_phase = PH_IDLE;
        endcase
        m_alive = 1'b1;
    endfunction

    task automatic compare();
        logic [NREQ-1:0] er;
        for (int i = 0; i < NREQ; i++) er[i] = m_alive & ~m_full[i];
        chk("req_rdy",    32'(req_rdy),    32'(er));
        chk("busy",       32'(busy),       32'(m_phase != PH_IDLE));
        chk("resp_rdy",   32'(resp_rdy),   32'(m_phase == PH_RESP));
        chk("resp_data",  32'(resp_data),  32'(m_resp_data));
        chk("resp_id",    32'(resp_id),    32'(m_resp_id));
        chk("resp_err",   32'(resp_err),   32'(m_resp_err));
        chk("dut_a_en",   32'(dut_a_en),   32'(m_phase == PH_A && dut_a_rdy));
        chk("dut_b_en",   32'(dut_b_en),   32'(m_phase == PH_B && dut_b_rdy));
        chk("dut_y_en",   32'(dut_y_en),   32'(m_phase == PH_Y && dut_y_rdy));
        chk("dut_a_data", 32'(dut_a_data), 32'(m_op_a));
        chk("dut_b_data", 32'(dut_b_data), 32'(m_op_b));
    endtask

    // One full clock: check at negedge, drive, capture handshakes, step models at posedge.
    task automatic cycle();
        @(negedge CLK);
        compare();
        RST_N      = s_rst;
        req_en     = s_req_en;
        req_a_data = s_a;
        req_b_data = s_b;
        dut_a_rdy  = s_a_rdy;
        dut_b_rdy  = s_b_rdy;
        dut_y_rdy  = s_y_rdy;
        resp_en    = s_resp_en;
        dut_y_data = u_a | u_b;
        #1;
        c_a_fire = dut_a_en; c_a_data = dut_a_data;
        c_b_fire = dut_b_en; c_b_data = dut_b_data;
        if (resp_rdy && resp_en) begin
            obs_id.push_back(int'(resp_id));
            obs_data.push_back(int'(resp_data));
            obs_err.push_back(int'(resp_err));
        end
        @(posedge CLK);
        model_update();
        if (c_a_fire) u_a = c_a_data;
        if (c_b_fire) u_b = c_b_data;
        #2;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic put(input int idx, input int a, input int b);
        s_req_en[idx]       = 1'b1;
        s_a[idx*DW +: DW]   = DW'(a);
        s_b[idx*DW +: DW]   = DW'(b);
    endtask

    initial begin
        int base;
        s_rst = 1'b1; s_req_en = '0; s_a = '0; s_b = '0;
        s_a_rdy = 1'b1; s_b_rdy = 1'b1; s_y_rdy = 1'b1; s_resp_en = 1'b0;
        RST_N = 1'b1; req_en = '0; req_a_data = '0; req_b_data = '0;
        dut_a_rdy = 1'b0; dut_b_rdy = 1'b0; dut_y_rdy = 1'b0; resp_en = 1'b0;
        dut_y_data = '0; u_a = '0; u_b = '0;
        c_a_fire = 1'b0; c_b_fire = 1'b0; c_a_data = '0; c_b_data = '0;
        model_reset();

        // reset release and single-op latency
        cycles(2);
        s_rst = 1'b0;
        cycle();
        chk("lit_rst_req_rdy", 32'(req_rdy), 32'h3);
        chk("lit_rst_busy", 32'(busy), 32'h0);
        chk("lit_rst_resp_rdy", 32'(resp_rdy), 32'h0);
        put(0, 1, 0);
        cycle();                       // E0: put
        s_req_en = '0;
        cycles(3);                     // E1..E3
        chk("lit_lat_early", 32'(resp_rdy), 32'h0);
        cycle();                       // E4: y fire
        chk("lit_lat_rdy", 32'(resp_rdy), 32'h1);
        chk("lit_lat_data", 32'(resp_data), 32'h1);
        chk("lit_lat_id", 32'(resp_id), 32'h0);
        chk("lit_lat_err", 32'(resp_err), 32'h0);
        s_resp_en = 1'b1;
        cycle();                       // E5: consumed
        chk("lit_lat_consumed", 32'(resp_rdy), 32'h0);

        // both requesters put together from rr_ptr = 0
        s_rst = 1'b1; cycle(); s_rst = 1'b0; cycle();
        base = obs_id.size();
        put(0, 0, 0); put(1, 1, 1);
        cycle(); s_req_en = '0; cycles(14);
        chk("lit_pair_cnt", 32'(obs_id.size()), 32'(base + 2));
        if (obs_id.size() >= base + 2) begin
            chk("lit_pair0_id", 32'(obs_id[base]), 32'd0);
            chk("lit_pair0_data", 32'(obs_data[base]), 32'd0);
            chk("lit_pair1_id", 32'(obs_id[base+1]), 32'd1);
            chk("lit_pair1_data", 32'(obs_data[base+1]), 32'd1);
        end
        base = obs_id.size();
        put(0, 3, 4); put(1, 8, 0);
        cycle(); s_req_en = '0; cycles(14);
        if (obs_id.size() >= base + 2) begin
            chk("lit_ptr_wrap_id", 32'(obs_id[base]), 32'd0);
            chk("lit_ptr_wrap_data", 32'(obs_data[base]), 32'd7);
            chk("lit_ptr_wrap_id1", 32'(obs_id[base+1]), 32'd1);
            chk("lit_ptr_wrap_data1", 32'(obs_data[base+1]), 32'd8);
        end else begin
            chk("lit_ptr_wrap_cnt", 32'(obs_id.size()), 32'(base + 2));
        end

        // both requesters always refilling: strict alternation
        base = obs_id.size();
        for (int n = 0; n < 60; n++) begin
            s_req_en = 2'b11;
            s_a = (NREQ*DW)'($urandom);
            s_b = (NREQ*DW)'($urandom);
            cycle();
        end
        s_req_en = '0;
        cycles(20);
        chk("lit_rot_ops", 32'(obs_id.size() >= base + 8), 32'h1);
        for (int j = 0; j < 8; j++) begin
            if (base + j < obs_id.size()) chk("lit_rot_id", 32'(obs_id[base+j]), 32'(j % 2));
        end

        // a_rdy held low: hold in SEND_A without b/y activity
        s_a_rdy = 1'b0;
        put(0, 5, 2);
        cycle(); s_req_en = '0; cycle();
        for (int j = 0; j < 5; j++) begin
            cycle();
            chk("lit_stall_a_en", 32'(dut_a_en), 32'h0);
            chk("lit_stall_b_en", 32'(dut_b_en), 32'h0);
            chk("lit_stall_busy", 32'(busy), 32'h1);
            chk("lit_stall_a_data", 32'(dut_a_data), 32'h5);
        end
        s_a_rdy = 1'b1;
        base = obs_id.size();
        cycles(8);
        if (obs_id.size() == base + 1) begin
            chk("lit_stall_data", 32'(obs_data[base]), 32'h7);
            chk("lit_stall_err", 32'(obs_err[base]), 32'h0);
        end else begin
            chk("lit_stall_cnt", 32'(obs_id.size()), 32'(base + 1));
        end

        // y never ready: timeout after exactly TO cycles in WAIT_Y
        s_y_rdy = 1'b0; s_resp_en = 1'b0;
        put(1, 6, 1);
        cycle(); s_req_en = '0;
        cycles(6);
        chk("lit_to_early", 32'(resp_rdy), 32'h0);
        cycle();
        chk("lit_to_rdy", 32'(resp_rdy), 32'h1);
        chk("lit_to_err", 32'(resp_err), 32'h1);
        chk("lit_to_data", 32'(resp_data), 32'h0);
        chk("lit_to_id", 32'(resp_id), 32'h1);
        base = obs_id.size();
        s_resp_en = 1'b1; s_y_rdy = 1'b1;
        put(0, 2, 8);
        cycle(); s_req_en = '0; cycles(8);
        if (obs_id.size() == base + 2) begin
            chk("lit_after_to_err", 32'(obs_err[base+1]), 32'h0);
            chk("lit_after_to_data", 32'(obs_data[base+1]), 32'ha);
            chk("lit_after_to_id", 32'(obs_id[base+1]), 32'h0);
        end else begin
            chk("lit_after_to_cnt", 32'(obs_id.size()), 32'(base + 2));
        end

        // reset pulse while waiting for y, with req1 buffered
        s_y_rdy = 1'b0;
        put(0, 1, 1);
        cycle(); s_req_en = '0; cycles(2);
        put(1, 3, 3);
        cycle(); s_req_en = '0;
        chk("lit_mid_busy", 32'(busy), 32'h1);
        base = obs_id.size();
        s_rst = 1'b1; cycle();
        s_rst = 1'b0; cycle();
        chk("lit_mid_req_rdy", 32'(req_rdy), 32'h3);
        chk("lit_mid_busy_after", 32'(busy), 32'h0);
        chk("lit_mid_resp_rdy", 32'(resp_rdy), 32'h0);
        s_y_rdy = 1'b1;
        cycles(6);
        chk("lit_mid_no_resp", 32'(obs_id.size()), 32'(base));

        // randomized traffic, backpressure and occasional resets
        for (int n = 0; n < 3000; n++) begin
            s_rst     = ($urandom_range(0, 399) == 0);
            s_req_en  = NREQ'($urandom);
            s_a       = (NREQ*DW)'($urandom);
            s_b       = (NREQ*DW)'($urandom);
            s_a_rdy   = ($urandom_range(0, 9) < 7);
            s_b_rdy   = ($urandom_range(0, 9) < 7);
            s_y_rdy   = ($urandom_range(0, 9) < 5);
            s_resp_en = ($urandom_range(0, 9) < 6);
            cycle();
        end
        s_rst = 1'b0; s_req_en = '0;
        s_a_rdy = 1'b1; s_b_rdy = 1'b1; s_y_rdy = 1'b1; s_resp_en = 1'b1;
        cycles(30);
        chk("lit_drain_idle", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
